// File: rtl/en_tick_gen.sv
// Programmable enable-tick generator: continuous or fixed-length burst of 1-cycle ticks,
// one tick every DIV cycles, with start/stop control and busy/done status.
module en_tick_gen #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  localparam logic [DIV_W-1:0]   DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [DIV_W-1:0]   div_q_r, period_m1_s, cnt_r, cnt_nxt_s;
  logic [BURST_W-1:0] burst_q_r, tcnt_r, tcnt_nxt_s;
  logic               mode_q_r;
  logic               accept_s, finish_s, due_s;
  logic               tick_r, busy_r, done_r;
  logic               tick_nxt_s, busy_nxt_s, done_nxt_s;

  // Decode start acceptance, burst completion and tick-due conditions
  always_comb begin
    period_m1_s = (div_q_r == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (div_q_r - DIV_ONE);
    accept_s    = (state_r == ST_IDLE) && start && !stop;
    // Completion is checked one edge after the last tick so that tick stays inside RUN
    finish_s    = (state_r == ST_RUN) && mode_q_r && (tcnt_r == burst_q_r);
    due_s       = (state_r == ST_RUN) && (cnt_r == period_m1_s);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; stop beats completion, completion beats a due tick
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop)          state_nxt_s = ST_IDLE;
        else if (finish_s) state_nxt_s = ST_DONE;
        else               state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Prescale and tick-count next values
  always_comb begin
    cnt_nxt_s  = cnt_r;
    tcnt_nxt_s = tcnt_r;
    if (accept_s) begin
      cnt_nxt_s  = {DIV_W{1'b0}};
      tcnt_nxt_s = {BURST_W{1'b0}};
    end else if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
      if (due_s) begin
        cnt_nxt_s = {DIV_W{1'b0}};
        if (mode_q_r && (tcnt_r != {BURST_W{1'b1}})) tcnt_nxt_s = tcnt_r + BURST_ONE;
        else                                         tcnt_nxt_s = tcnt_r;
      end else begin
        cnt_nxt_s = cnt_r + DIV_ONE;
      end
    end else begin
      cnt_nxt_s  = cnt_r;
      tcnt_nxt_s = tcnt_r;
    end
  end

  // Counters and start-time configuration capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= {DIV_W{1'b0}};
      tcnt_r    <= {BURST_W{1'b0}};
      div_q_r   <= {DIV_W{1'b0}};
      burst_q_r <= {BURST_W{1'b0}};
      mode_q_r  <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tcnt_r <= tcnt_nxt_s;
      if (accept_s) begin
        div_q_r   <= div;
        burst_q_r <= burst_len;
        mode_q_r  <= mode;
      end
    end
  end

  // Output next values, derived from the transition being taken
  always_comb begin
    tick_nxt_s = (state_r == ST_RUN) && (state_nxt_s == ST_RUN) && due_s;
    busy_nxt_s = (state_nxt_s == ST_RUN);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      tick_r <= tick_nxt_s;
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign tick = tick_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_en_tick_gen.sv
// Directed bench for en_tick_gen: per-edge vector table plus hand sequences for
// stop-on-due-tick, start during RUN, div=0 and asynchronous reset mid-burst.
module tb_en_tick_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [7:0] div = 8'd0, burst_len = 8'd0;
  logic       tick, busy, done;
  logic [3:0] q4;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       start, stop, mode;
    logic [7:0] div, bl;
    logic       t, b, d;
  } vec_t;

  vec_t vecs[$];

  en_tick_gen #(.DIV_W(8), .BURST_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .div(div), .burst_len(burst_len), .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit counter fed by tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q4 <= 4'd0;
    else if (tick) q4 <= q4 + 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic t, input logic b, input logic d);
    chk({name, " tick"}, int'(tick), int'(t));
    chk({name, " busy"}, int'(busy), int'(b));
    chk({name, " done"}, int'(done), int'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic md,
                       input logic [7:0] dv, input logic [7:0] bl);
    start = st; stop = sp; mode = md; div = dv; burst_len = bl;
  endtask

  task automatic add(input logic st, input logic sp, input logic md, input logic [7:0] dv,
                     input logic [7:0] bl, input logic t, input logic b, input logic d);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.div = dv; v.bl = bl;
    v.t = t; v.b = b; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic pulse_reset();
    #1 reset_n = 1'b0;
    #1 chk3("async reset", 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    // Burst div=2 len=4: ticks after 2,4,6,8; done after 9; start in DONE ignored
    add(1, 0, 1, 8'd2, 8'd4, 0, 1, 0);
    for (int e = 1; e <= 8; e++) add(0, 0, 1, 8'd2, 8'd4, (e % 2 == 0), 1, 0);
    add(0, 0, 0, 8'd9, 8'd9, 0, 0, 1);
    add(1, 0, 0, 8'd9, 8'd9, 0, 0, 0);
    add(0, 0, 0, 8'd9, 8'd9, 0, 0, 0);
    // start and stop together: stop wins
    add(1, 1, 0, 8'd3, 8'd0, 0, 0, 0);
    add(0, 0, 0, 8'd3, 8'd0, 0, 0, 0);
    // Burst with len 0: RUN for one cycle, then DONE, no tick
    add(1, 0, 1, 8'd5, 8'd0, 0, 1, 0);
    add(0, 0, 0, 8'd5, 8'd0, 0, 0, 1);
    add(0, 0, 0, 8'd5, 8'd0, 0, 0, 0);
    // Continuous div=1: tick every cycle, then stop
    add(1, 0, 0, 8'd1, 8'd0, 0, 1, 0);
    add(0, 0, 1, 8'd9, 8'd0, 1, 1, 0);
    add(0, 0, 1, 8'd9, 8'd0, 1, 1, 0);
    add(0, 1, 0, 8'd1, 8'd0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 chk3("reset state", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].div, vecs[i].bl);
      step();
      chk3($sformatf("vec%0d", i), vecs[i].t, vecs[i].b, vecs[i].d);
    end

    // Continuous div=3 driving the downstream counter
    pulse_reset();
    drive(1, 0, 0, 8'd3, 8'd0); step();
    chk3("c3 e0", 1'b0, 1'b1, 1'b0);
    drive(0, 0, 0, 8'd3, 8'd0);
    for (int e = 1; e <= 13; e++) begin
      step();
      chk($sformatf("c3 tick e%0d", e), int'(tick), int'(e % 3 == 0));
    end
    chk("c3 counter Q", int'(q4), 4);
    stop = 1'b1; step(); stop = 1'b0;
    chk3("c3 stopped", 1'b0, 1'b0, 1'b0);

    // Stop at the edge where a tick is due
    drive(1, 0, 0, 8'd4, 8'd0); step();
    drive(0, 0, 0, 8'd4, 8'd0);
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("s4 tick e%0d", e), int'(tick), int'(e == 4));
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk3("s4 stop e8", 1'b0, 1'b0, 1'b0);
    step();
    chk3("s4 e9", 1'b0, 1'b0, 1'b0);

    // start with new div during RUN is ignored
    drive(1, 0, 0, 8'd3, 8'd0); step();
    drive(0, 0, 0, 8'd3, 8'd0); step();
    drive(1, 0, 1, 8'd7, 8'd1); step();
    chk3("r e2", 1'b0, 1'b1, 1'b0);
    drive(0, 0, 1, 8'd7, 8'd1);
    for (int e = 3; e <= 10; e++) begin
      step();
      chk($sformatf("r tick e%0d", e), int'(tick), int'(e % 3 == 0));
    end
    chk("r busy", int'(busy), 1);
    stop = 1'b1; step(); stop = 1'b0;

    // div=0 behaves as div=1
    drive(1, 0, 0, 8'd0, 8'd0); step();
    chk3("d0 e0", 1'b0, 1'b1, 1'b0);
    drive(0, 0, 0, 8'd0, 8'd0);
    for (int e = 1; e <= 3; e++) begin
      step();
      chk3($sformatf("d0 e%0d", e), 1'b1, 1'b1, 1'b0);
    end
    stop = 1'b1; step(); stop = 1'b0;

    // Reset mid-burst, then a fresh burst starts from tick count 0
    drive(1, 0, 1, 8'd2, 8'd4); step();
    drive(0, 0, 0, 8'd5, 8'd5);
    for (int e = 1; e <= 4; e++) step();
    chk3("mb e4", 1'b1, 1'b1, 1'b0);
    pulse_reset();
    drive(1, 0, 1, 8'd2, 8'd2); step();
    drive(0, 0, 0, 8'd2, 8'd2);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk3($sformatf("nb e%0d", e), (e % 2 == 0), 1'b1, 1'b0);
    end
    step();
    chk3("nb e5", 1'b0, 1'b0, 1'b1);
    step();
    chk3("nb e6", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
